// File: rtl/seq_arb_pkg.sv
// Shared types and defaults for the sequenced datapath arbiter.
package seq_arb_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_arb_ctrl_rr_arb.sv
// Combinational requester pick: round-robin from ptr, or lowest index
// when SEQ_FIXED_PRIO_EN is defined (ptr port then disappears).
module rr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
`ifndef SEQ_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] sel;

`ifdef SEQ_FIXED_PRIO_EN
    // Lowest set request bit wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel = IDX_W'(k);
            if (!found && req[sel]) begin
                found        = 1'b1;
                gnt_oh[sel]  = 1'b1;
                gnt_idx      = sel;
            end
        end
    end
`else
    // First set request bit at or after ptr, wrapping past NREQ-1.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel = IDX_W'((32'(ptr) + k) % NREQ);
            if (!found && req[sel]) begin
                found        = 1'b1;
                gnt_oh[sel]  = 1'b1;
                gnt_idx      = sel;
            end
        end
    end
`endif

endmodule

// File: rtl/seq_arb_ctrl.sv
// Shares one datapath among NREQ requesters: arbitrate, then run a
// CLR -> LOAD -> RUN x len -> DONE sequence for the winner.
// Build option: SEQ_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module seq_arb_ctrl
    import seq_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  ds_rst,
    output logic                  ds_load,
    output logic                  ds_enable
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    seq_state_t       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [NREQ-1:0]  grant_d, done_d;
    logic             busy_d, ds_rst_d, ds_load_d, ds_enable_d;

    logic [NREQ-1:0]  arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic [LEN_W-1:0] len_arr [NREQ];

    // Unpack the flat length bus per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_arr[g] = len[g*LEN_W +: LEN_W];
    end

`ifndef SEQ_FIXED_PRIO_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .ptr     (ptr_q),
        .req     (req),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    // Advance the round-robin pointer past each new winner.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |req) begin
            ptr_d = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`else
    rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );
`endif

    // Next state, counters and the registered-output values for the next cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        cnt_d   = cnt_q;
        len_d   = len_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = CLR;
                    grant_d = arb_oh;
                    len_d   = len_arr[arb_idx];
                    cnt_d   = '0;
                end
            end
            CLR: begin
                state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Outputs are decoded from the state being entered so they line up with it.
        ds_rst_d    = (state_d == CLR);
        ds_load_d   = (state_d == LOAD);
        ds_enable_d = (state_d == LOAD) || (state_d == RUN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE) ? grant : '0;
    end

    // State, counter and output registers; reset forces the idle/datapath-reset view.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            ds_rst    <= 1'b1;
            ds_load   <= 1'b0;
            ds_enable <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            grant     <= grant_d;
            done      <= done_d;
            busy      <= busy_d;
            ds_rst    <= ds_rst_d;
            ds_load   <= ds_load_d;
            ds_enable <= ds_enable_d;
        end
    end

endmodule

// File: tb/tb_seq_arb_ctrl.sv
// Self-checking bench for seq_arb_ctrl: directed scenarios plus random traffic
// against a transaction-level model (owner, length, cycle offset into the grant).
module tb_seq_arb_ctrl;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned LW    = NREQ * LEN_W;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NREQ-1:0] req;
    logic [LW-1:0]   len;
    logic [NREQ-1:0] grant, done;
    logic            busy, ds_rst, ds_load, ds_enable;

    int checks = 0;
    int errors = 0;

    // Model: an active grant is owner + latched length + offset since grant.
    bit m_active;
    int m_owner, m_len, m_off, m_ptr;
    bit m_rst_hold;

    seq_arb_ctrl #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .ds_rst    (ds_rst),
        .ds_load   (ds_load),
        .ds_enable (ds_enable)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef SEQ_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (r[idx]) return idx;
        end
`endif
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int w;
        m_rst_hold = 1'b0;
        if (m_active) begin
            m_off++;
            if (m_off > m_len + 2) m_active = 1'b0;
        end else if (req != '0) begin
            w        = pick(req);
            m_active = 1'b1;
            m_owner  = w;
            m_len    = int'((len >> (w * LEN_W)) & LW'((1 << LEN_W) - 1));
            m_off    = 0;
            m_ptr    = (w + 1) % NREQ;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg, ed;
        logic            eb, er, el, ee;
        if (m_active) begin
            eg = NREQ'(1) << m_owner;
            eb = 1'b1;
            er = (m_off == 0);
            el = (m_off == 1);
            ee = (m_off >= 1) && (m_off <= m_len + 1);
            ed = (m_off == m_len + 2) ? eg : '0;
        end else begin
            eg = '0; ed = '0; eb = 1'b0; el = 1'b0; ee = 1'b0;
            er = m_rst_hold;
        end
        check_val("grant",     32'(grant),     32'(eg));
        check_val("done",      32'(done),      32'(ed));
        check_val("busy",      32'(busy),      32'(eb));
        check_val("ds_rst",    32'(ds_rst),    32'(er));
        check_val("ds_load",   32'(ds_load),   32'(el));
        check_val("ds_enable", 32'(ds_enable), 32'(ee));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Assert reset away from the edge, check it takes effect at once, then release.
    task automatic do_reset();
        rstn = 1'b1;
        #1;
        m_active   = 1'b0;
        m_ptr      = 0;
        m_rst_hold = 1'b1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        req  = '0;
        rstn = 1'b0;
        #1;
        check_outputs();
    endtask

    // Run one grant for requester 'who', counting datapath strobes.
    task automatic run_seq(input int who, input int budget, input int drop_at,
                           output int n_rst, output int n_ld, output int n_en, output int done_at);
        n_rst = 0; n_ld = 0; n_en = 0; done_at = -1;
        for (int k = 1; k <= budget && done_at < 0; k++) begin
            cycle();
            if (ds_rst)    n_rst++;
            if (ds_load)   n_ld++;
            if (ds_enable) n_en++;
            if (done[who]) begin
                done_at  = k;
                req[who] = 1'b0;
            end
            if (k == drop_at) req[who] = 1'b0;
        end
        check_val("done_seen", 32'(done_at >= 0), 32'd1);
    endtask

    initial begin
        int n_rst, n_ld, n_en, done_at, t;
        logic [LEN_W-1:0] lf;

        rstn = 1'b1;
        req  = '0;
        len  = '0;
        m_active = 1'b0; m_owner = 0; m_len = 0; m_off = 0; m_ptr = 0; m_rst_hold = 1'b1;
        @(negedge clk);
        do_reset();
        repeat (2) cycle();

        // Single requester 0 with length 3.
        len = LW'(3);
        req = NREQ'(1);
        run_seq(0, 20, -1, n_rst, n_ld, n_en, done_at);
        check_val("t1_rst_cycles",  32'(n_rst),   32'd1);
        check_val("t1_load_cycles", 32'(n_ld),    32'd1);
        check_val("t1_en_cycles",   32'(n_en),    32'd4);
        check_val("t1_done_cycle",  32'(done_at), 32'd6);
        cycle();
        check_val("t1_grant_clear", 32'(grant),   32'd0);

        // All requesters held with zero length: grant rotation and 4-cycle cadence.
        @(negedge clk);
        do_reset();
        len = '0;
        req = '1;
        for (int g = 0; g < 5; g++) begin
            logic [NREQ-1:0] eg;
`ifdef SEQ_FIXED_PRIO_EN
            eg = NREQ'(1);
`else
            eg = NREQ'(1) << (g % NREQ);
`endif
            t = 0;
            while (grant == '0 && t < 10) begin cycle(); t++; end
            check_val("t2_grant_order", 32'(grant), 32'(eg));
            if (g > 0) check_val("t2_grant_gap", 32'(t), 32'd1);
            t = 0;
            while (grant != '0 && t < 10) begin cycle(); t++; end
            check_val("t2_grant_hold", 32'(t), 32'd3);
        end
        req = '0;
        repeat (4) cycle();

        // Requester 1 at maximum length drops its request during RUN.
        lf  = '1;
        len = LW'(lf) << LEN_W;
        req = NREQ'(2);
        run_seq(1, 30, 5, n_rst, n_ld, n_en, done_at);
        check_val("t3_en_cycles",  32'(n_en),    32'd16);
        check_val("t3_done_cycle", 32'(done_at), 32'd18);
        repeat (2) cycle();

        // Reset in the middle of a length-8 run.
        len = LW'(8);
        req = NREQ'(1);
        repeat (5) cycle();
        check_val("t4_in_run", 32'(ds_enable & ~ds_load), 32'd1);
        do_reset();
        repeat (3) cycle();

        // Random traffic: requesters raise at will, hold until done, occasionally drop early.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (!req[i] && ($urandom_range(3) == 0)) req[i] = 1'b1;
                else if (req[i] && ($urandom_range(31) == 0)) req[i] = 1'b0;
            end
            len = LW'($urandom());
            if ($urandom_range(199) == 0) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
